// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and trap sequencer for the execute-stage system path.
// Handles CSR read/modify/write, ecall/ebreak/illegal-CSR trap entry and mret.
// Each request runs a short multi-cycle FSM. Execute stays stalled until the
// FSM is back in IDLE.
module csr_trap_unit #(
    parameter int                XLEN        = 64,
    parameter logic [XLEN-1:0]   RESET_MTVEC = 64'h0000_0000_8000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            sys_valid,
    output logic            sys_ready,
    input  logic [4:0]      e_cause,
    input  logic [XLEN-1:0] e_tval,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] pc,
    output logic            rd_wen,
    output logic [XLEN-1:0] rd_data,
    output logic            stall,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc
);

    localparam logic [4:0] SYSOP_ECALL  = 5'd1;
    localparam logic [4:0] SYSOP_EBREAK = 5'd2;
    localparam logic [4:0] SYSOP_RET    = 5'd3;
    localparam logic [4:0] SYSOP_CSR_W  = 5'd4;
    localparam logic [4:0] SYSOP_CSR_S  = 5'd5;
    localparam logic [4:0] SYSOP_CSR_C  = 5'd6;

    typedef enum logic [2:0] {
        S_IDLE, S_CSR_RD, S_CSR_WB, S_TRAP_SAVE, S_TRAP_JUMP, S_RET_JUMP
    } state_t;

    state_t          state_q;
    logic [4:0]      cause_q;
    logic [11:0]     addr_q;
    logic [XLEN-1:0] rs1_q, pc_q;
    logic            mie_q, mpie_q;
    logic [XLEN-1:0] mtvec_q, mepc_q, mcause_q, mtval_q, mscratch_q;
    logic            rd_wen_q, redirect_q;
    logic [XLEN-1:0] rd_data_q, redirect_pc_q;

    logic            accept;
    logic            csr_legal;
    logic [XLEN-1:0] csr_rdata;
    logic [XLEN-1:0] csr_wdata;
    logic            unused_tval;

    // Only the low 12 bits of e_tval carry the CSR address
    assign unused_tval = ^e_tval[XLEN-1:12];

    // Causes above CSR_C are treated like "no op" and never accepted
    assign accept    = (state_q == S_IDLE) && sys_valid &&
                       (e_cause != 5'd0) && (e_cause <= SYSOP_CSR_C);
    assign sys_ready = (state_q == S_IDLE);
    assign stall     = accept || (state_q != S_IDLE);

    assign rd_wen      = rd_wen_q;
    assign rd_data     = rd_data_q;
    assign redirect    = redirect_q;
    assign redirect_pc = redirect_pc_q;

    // CSR read mux and legality decode for the latched address
    always_comb begin
        csr_legal = 1'b1;
        csr_rdata = '0;
        case (addr_q)
            12'h300: csr_rdata = {{(XLEN-8){1'b0}}, mpie_q, 3'b000, mie_q, 3'b000};
            12'h305: csr_rdata = mtvec_q;
            12'h340: csr_rdata = mscratch_q;
            12'h341: csr_rdata = mepc_q;
            12'h342: csr_rdata = mcause_q;
            12'h343: csr_rdata = mtval_q;
            default: csr_legal = 1'b0;
        endcase
    end

    // New CSR value from the old value (held in rd_data_q) and the operand
    always_comb begin
        csr_wdata = rs1_q;
        case (cause_q)
            SYSOP_CSR_S: csr_wdata = rd_data_q | rs1_q;
            SYSOP_CSR_C: csr_wdata = rd_data_q & ~rs1_q;
            default:     csr_wdata = rs1_q;
        endcase
    end

    // Sequencer: latches the request, walks the op, updates CSRs, emits pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cause_q       <= '0;
            addr_q        <= '0;
            rs1_q         <= '0;
            pc_q          <= '0;
            mie_q         <= 1'b0;
            mpie_q        <= 1'b0;
            mtvec_q       <= {RESET_MTVEC[XLEN-1:2], 2'b00};
            mepc_q        <= '0;
            mcause_q      <= '0;
            mtval_q       <= '0;
            mscratch_q    <= '0;
            rd_wen_q      <= 1'b0;
            rd_data_q     <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            rd_wen_q   <= 1'b0;
            redirect_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        cause_q <= e_cause;
                        addr_q  <= e_tval[11:0];
                        rs1_q   <= rs1_data;
                        pc_q    <= pc;
                        if (e_cause == SYSOP_RET) begin
                            // mret target is known now, so redirect lands one cycle later
                            redirect_q    <= 1'b1;
                            redirect_pc_q <= mepc_q;
                            state_q       <= S_RET_JUMP;
                        end else if (e_cause == SYSOP_ECALL || e_cause == SYSOP_EBREAK) begin
                            state_q <= S_TRAP_SAVE;
                        end else begin
                            state_q <= S_CSR_RD;
                        end
                    end
                end
                S_CSR_RD: begin
                    if (csr_legal) begin
                        rd_data_q <= csr_rdata;
                        rd_wen_q  <= 1'b1;
                        state_q   <= S_CSR_WB;
                    end else begin
                        state_q <= S_TRAP_SAVE;
                    end
                end
                S_CSR_WB: begin
                    case (addr_q)
                        12'h300: begin
                            mie_q  <= csr_wdata[3];
                            mpie_q <= csr_wdata[7];
                        end
                        12'h305: mtvec_q    <= {csr_wdata[XLEN-1:2], 2'b00};
                        12'h340: mscratch_q <= csr_wdata;
                        12'h341: mepc_q     <= {csr_wdata[XLEN-1:1], 1'b0};
                        12'h342: mcause_q   <= csr_wdata;
                        12'h343: mtval_q    <= csr_wdata;
                        default: ;
                    endcase
                    state_q <= S_IDLE;
                end
                S_TRAP_SAVE: begin
                    mepc_q <= {pc_q[XLEN-1:1], 1'b0};
                    if (cause_q == SYSOP_ECALL) begin
                        mcause_q <= 64'd11;
                        mtval_q  <= '0;
                    end else if (cause_q == SYSOP_EBREAK) begin
                        mcause_q <= 64'd3;
                        mtval_q  <= pc_q;
                    end else begin
                        mcause_q <= 64'd2;
                        mtval_q  <= {{(XLEN-12){1'b0}}, addr_q};
                    end
                    mpie_q        <= mie_q;
                    mie_q         <= 1'b0;
                    // mtvec cannot change inside a trap sequence, so read it here
                    redirect_q    <= 1'b1;
                    redirect_pc_q <= {mtvec_q[XLEN-1:2], 2'b00};
                    state_q       <= S_TRAP_JUMP;
                end
                S_TRAP_JUMP: state_q <= S_IDLE;
                S_RET_JUMP: begin
                    mie_q   <= mpie_q;
                    mpie_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_csr_trap_unit.sv
// Directed bench for csr_trap_unit: vector tables plus a reset-mid-trap sequence.
module tb_csr_trap_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        sys_valid;
    logic        sys_ready;
    logic [4:0]  e_cause;
    logic [63:0] e_tval;
    logic [63:0] rs1_data;
    logic [63:0] pc;
    logic        rd_wen;
    logic [63:0] rd_data;
    logic        stall;
    logic        redirect;
    logic [63:0] redirect_pc;

    int checks   = 0;
    int failures = 0;

    csr_trap_unit dut (
        .clk(clk), .rst(rst), .sys_valid(sys_valid), .sys_ready(sys_ready),
        .e_cause(e_cause), .e_tval(e_tval), .rs1_data(rs1_data), .pc(pc),
        .rd_wen(rd_wen), .rd_data(rd_data), .stall(stall),
        .redirect(redirect), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  cause;
        logic [11:0] addr;
        logic [63:0] rs1;
        logic [63:0] pc;
        logic        exp_stall;
        int          wen_cyc;   // 0 = no rd_wen expected
        logic [63:0] wen_data;
        int          red_cyc;   // 0 = no redirect expected
        logic [63:0] red_pc;
        int          rdy_cyc;
    } vec_t;

    vec_t tbl1[$];
    vec_t tbl2[$];

    function automatic vec_t csr_op(input logic [4:0] c, input logic [11:0] a,
                                    input logic [63:0] r, input logic [63:0] old);
        vec_t v;
        v = '{c, a, r, 64'h0, 1'b1, 2, old, 0, 64'h0, 3};
        return v;
    endfunction

    function automatic vec_t jump_op(input logic [4:0] c, input logic [11:0] a,
                                     input logic [63:0] p, input int rc,
                                     input logic [63:0] rpc, input int rdy);
        vec_t v;
        v = '{c, a, 64'h5, p, 1'b1, 0, 64'h0, rc, rpc, rdy};
        return v;
    endfunction

    function automatic vec_t nop_op(input logic [4:0] c);
        vec_t v;
        v = '{c, 12'h340, 64'h1234, 64'h0, 1'b0, 0, 64'h0, 0, 64'h0, 1};
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Issue one request and watch the following cycles until sys_ready returns
    task automatic run_vec(input vec_t v, input string tag);
        int          wen_cyc, red_cyc, rdy_cyc, wen_cnt, red_cnt, both;
        logic [63:0] wdat, rpc;
        logic        acc_stall;
        wen_cyc = 0; red_cyc = 0; rdy_cyc = -1; wen_cnt = 0; red_cnt = 0; both = 0;
        wdat = '0; rpc = '0;
        @(negedge clk);
        sys_valid = 1'b1; e_cause = v.cause; e_tval = {52'h0, v.addr};
        rs1_data = v.rs1; pc = v.pc;
        #1 acc_stall = stall;
        @(posedge clk);
        #1 sys_valid = 1'b0; e_cause = 5'd0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (rd_wen) begin
                wen_cnt++;
                if (wen_cyc == 0) begin wen_cyc = k; wdat = rd_data; end
            end
            if (redirect) begin
                red_cnt++;
                if (red_cyc == 0) begin red_cyc = k; rpc = redirect_pc; end
            end
            if (rd_wen && redirect) both++;
            if (sys_ready) begin rdy_cyc = k; break; end
        end
        chk({tag, "_stall"},    64'(acc_stall), 64'(v.exp_stall));
        chk({tag, "_wen_cyc"},  64'(wen_cyc),   64'(v.wen_cyc));
        chk({tag, "_wen_cnt"},  64'(wen_cnt),   64'((v.wen_cyc != 0) ? 1 : 0));
        if (v.wen_cyc != 0) chk({tag, "_rd_data"}, wdat, v.wen_data);
        chk({tag, "_red_cyc"},  64'(red_cyc),   64'(v.red_cyc));
        chk({tag, "_red_cnt"},  64'(red_cnt),   64'((v.red_cyc != 0) ? 1 : 0));
        if (v.red_cyc != 0) chk({tag, "_red_pc"}, rpc, v.red_pc);
        chk({tag, "_ready"},    64'(rdy_cyc),   64'(v.rdy_cyc));
        chk({tag, "_collide"},  64'(both),      64'h0);
    endtask

    initial begin
        // Phase 1: CSR ops and trap flows after reset
        tbl1.push_back(csr_op(5'd4, 12'h340, 64'hDEAD_BEEF, 64'h0));
        tbl1.push_back(csr_op(5'd5, 12'h340, 64'h1, 64'hDEAD_BEEF));
        tbl1.push_back(csr_op(5'd5, 12'h340, 64'h0, 64'hDEAD_BEEF));
        tbl1.push_back(csr_op(5'd4, 12'h300, 64'h8, 64'h0));
        tbl1.push_back(jump_op(5'd1, 12'h000, 64'h8000_0100, 2, 64'h8000_0000, 3));
        tbl1.push_back(csr_op(5'd5, 12'h341, 64'h0, 64'h8000_0100));
        tbl1.push_back(csr_op(5'd5, 12'h342, 64'h0, 64'd11));
        tbl1.push_back(csr_op(5'd5, 12'h300, 64'h0, 64'h80));
        tbl1.push_back(jump_op(5'd3, 12'h000, 64'h0, 1, 64'h8000_0100, 2));
        tbl1.push_back(csr_op(5'd5, 12'h300, 64'h0, 64'h88));
        tbl1.push_back(jump_op(5'd6, 12'h7C0, 64'h200, 3, 64'h8000_0000, 4));
        tbl1.push_back(csr_op(5'd5, 12'h342, 64'h0, 64'd2));
        tbl1.push_back(csr_op(5'd5, 12'h343, 64'h0, 64'h7C0));
        tbl1.push_back(csr_op(5'd5, 12'h341, 64'h0, 64'h200));
        tbl1.push_back(csr_op(5'd4, 12'h305, 64'h8000_2003, 64'h8000_0000));
        tbl1.push_back(csr_op(5'd5, 12'h305, 64'h0, 64'h8000_2000));
        tbl1.push_back(jump_op(5'd2, 12'h000, 64'h40, 2, 64'h8000_2000, 3));
        tbl1.push_back(csr_op(5'd5, 12'h342, 64'h0, 64'd3));
        tbl1.push_back(csr_op(5'd5, 12'h343, 64'h0, 64'h40));
        tbl1.push_back(nop_op(5'd0));
        tbl1.push_back(nop_op(5'd7));
        tbl1.push_back(csr_op(5'd5, 12'h340, 64'h0, 64'hDEAD_BEEF));
        tbl1.push_back(csr_op(5'd4, 12'h300, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0));
        tbl1.push_back(csr_op(5'd6, 12'h300, 64'h8, 64'h88));
        tbl1.push_back(csr_op(5'd5, 12'h300, 64'h0, 64'h80));
        tbl1.push_back(csr_op(5'd4, 12'h341, 64'h123, 64'h40));
        tbl1.push_back(csr_op(5'd5, 12'h341, 64'h0, 64'h122));
        // Phase 2: state after a reset taken mid-trap
        tbl2.push_back(csr_op(5'd5, 12'h341, 64'h0, 64'h0));
        tbl2.push_back(csr_op(5'd5, 12'h305, 64'h0, 64'h8000_0000));
        tbl2.push_back(csr_op(5'd5, 12'h340, 64'h0, 64'h0));
        tbl2.push_back(csr_op(5'd5, 12'h300, 64'h0, 64'h0));
        tbl2.push_back(jump_op(5'd1, 12'h000, 64'h10, 2, 64'h8000_0000, 3));

        rst = 1'b1; sys_valid = 1'b0; e_cause = '0; e_tval = '0; rs1_data = '0; pc = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_sys_ready",   64'(sys_ready), 64'h1);
        chk("rst_stall",       64'(stall),     64'h0);
        chk("rst_rd_wen",      64'(rd_wen),    64'h0);
        chk("rst_redirect",    64'(redirect),  64'h0);
        chk("rst_rd_data",     rd_data,        64'h0);
        chk("rst_redirect_pc", redirect_pc,    64'h0);

        foreach (tbl1[i]) run_vec(tbl1[i], $sformatf("t1v%0d", i));

        // Reset asserted while the unit sits in TRAP_SAVE
        @(negedge clk);
        sys_valid = 1'b1; e_cause = 5'd1; e_tval = '0; pc = 64'h500;
        @(posedge clk);
        #1 sys_valid = 1'b0; e_cause = 5'd0; rst = 1'b1;
        @(negedge clk);
        chk("save_stall", 64'(stall),     64'h1);
        chk("save_ready", 64'(sys_ready), 64'h0);
        @(negedge clk);
        chk("rstsave_redirect", 64'(redirect),  64'h0);
        chk("rstsave_ready",    64'(sys_ready), 64'h1);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("rstsave_quiet%0d", k), 64'(redirect | rd_wen), 64'h0);
        end

        foreach (tbl2[i]) run_vec(tbl2[i], $sformatf("t2v%0d", i));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
